// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined execute-stage ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  // aluOp encodings
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_ORR = 3'b100;
  localparam logic [2:0] OP_EOR = 3'b101;
  localparam logic [2:0] OP_ROR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Bit positions inside the {N,Z,C,V} flag register
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier returning the low WIDTH bits of a*b.
// Latency: start edge loads operands, WIDTH further edges of one bit each; done is high in the last step's cycle.
// Backpressure: none; the caller must consume product in the cycle done is high.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset (aborts a running multiply)
//   start           load a/b and begin (ignored while running is the caller's concern)
//   a, b            multiplicand, multiplier
//   done            final step happens on the coming edge; product is valid now
//   product         low WIDTH bits of a*b (combinational, valid when done)
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;

  // One partial product per cycle; bits shifted past WIDTH are the discarded high half.
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
  assign done    = run && (cnt == CW'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      run    <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with architectural NZCV register and iterative MUL.
// Latency: accept at edge t -> result after edge t+1; MUL -> result after edge t+WIDTH+1.
// Backpressure: valid/ready; result held while out_valid && !out_ready, no accept meanwhile.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_valid/in_ready             operation handshake (aluOp, aluIn1, aluIn2, set_flags)
//   aluIn1                        operand 1; SUB subtrahend; ROR amount
//   aluIn2                        operand 2; SUB minuend; ROR data
//   out_valid/out_ready, aluOut   result handshake
//   flags_out                     {N,Z,C,V} register; flags_we/flags_in load it directly
//   busy                          multiply in progress
module alu_pipe
  import alu_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluOp,
  input  logic [WIDTH-1:0] aluIn1,
  input  logic [WIDTH-1:0] aluIn2,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluOut,
  output logic [3:0]       flags_out,
  input  logic             flags_we,
  input  logic [3:0]       flags_in,
  output logic             busy
);

  localparam int M  = WIDTH - 1;
  localparam int LW = $clog2(WIDTH);

  state_t state_q, state_d;

  // Capture stage: holds an accepted op (or a finished product) until the result register frees up.
  logic             s1_vld;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_sf;
  logic             s1_cin;

  logic [3:0]       flags_q, flags_d;
  logic             accept, s1_adv, mul_start, mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   res;
  logic               c_new, v_new;
  logic [WIDTH:0]     sum;
  logic [LW-1:0]      ror_amt;
  logic [2*WIDTH-1:0] ror_wide;

  assign in_ready  = (state_q == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign s1_adv    = s1_vld && (!out_valid || out_ready);
  assign mul_start = accept && (aluOp == OP_MUL);
  assign busy      = (state_q == MUL_BUSY);
  assign flags_out = flags_q;
  assign ror_amt   = s1_a[LW-1:0];

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (aluIn1),
    .b       (aluIn2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (mul_start) state_d = MUL_BUSY;
      MUL_BUSY: if (mul_done)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Result and C/V for the op in the capture stage; C/V default to "unchanged".
  always_comb begin
    res      = '0;
    c_new    = flags_q[FLAG_C];
    v_new    = flags_q[FLAG_V];
    sum      = '0;
    ror_wide = '0;
    case (s1_op)
      OP_ADD: begin
        sum   = {1'b0, s1_a} + {1'b0, s1_b};
        res   = sum[M:0];
        c_new = sum[WIDTH];
        v_new = (s1_a[M] == s1_b[M]) && (res[M] != s1_a[M]);
      end
      OP_ADC: begin
        sum   = {1'b0, s1_a} + {1'b0, s1_b} + (WIDTH+1)'(s1_cin);
        res   = sum[M:0];
        c_new = sum[WIDTH];
        v_new = (s1_a[M] == s1_b[M]) && (res[M] != s1_a[M]);
      end
      OP_SUB: begin
        res   = s1_b - s1_a;
        c_new = (s1_b >= s1_a);
        v_new = (s1_a[M] != s1_b[M]) && (res[M] != s1_b[M]);
      end
      OP_AND: res = s1_a & s1_b;
      OP_ORR: res = s1_a | s1_b;
      OP_EOR: res = s1_a ^ s1_b;
      OP_ROR: begin
        ror_wide = {s1_b, s1_b} >> ror_amt;
        res      = ror_wide[M:0];
        if (ror_amt != '0) c_new = res[M];
      end
      OP_MUL:  res = s1_a;  // product was parked in s1_a when the multiplier finished
      default: res = '0;
    endcase
  end

  // External load overrides a same-edge commit.
  always_comb begin
    flags_d = flags_q;
    if (s1_adv && s1_sf) flags_d = {res[M], (res == '0), c_new, v_new};
    if (flags_we)        flags_d = flags_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      flags_q   <= FLAGS_RST;
      out_valid <= 1'b0;
      aluOut    <= '0;
      s1_vld    <= 1'b0;
      s1_op     <= OP_ADD;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_sf     <= 1'b0;
      s1_cin    <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;

      if (s1_adv) begin
        out_valid <= 1'b1;
        aluOut    <= res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // MUL sits in the capture stage invalid until its product arrives.
      if (accept)        s1_vld <= (aluOp != OP_MUL);
      else if (mul_done) s1_vld <= 1'b1;
      else if (s1_adv)   s1_vld <= 1'b0;

      if (accept) begin
        s1_op  <= aluOp;
        s1_a   <= aluIn1;
        s1_b   <= aluIn2;
        s1_sf  <= set_flags;
        // flags_d already includes a commit retiring on this edge, giving ADC the forwarded carry.
        s1_cin <= flags_d[FLAG_C];
      end else if (mul_done) begin
        s1_a <= mul_product;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed ops push expected results, a monitor pops on each output handshake.
// Latency: n/a.
// Backpressure: exercises out_ready hold and MUL busy stalls.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [2:0]    aluOp;
  logic [W-1:0]  aluIn1, aluIn2;
  logic          set_flags;
  logic          out_valid, out_ready;
  logic [W-1:0]  aluOut;
  logic [3:0]    flags_out;
  logic          flags_we;
  logic [3:0]    flags_in;
  logic          busy;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_pipe #(.WIDTH(W), .FLAGS_RST(4'b0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluOp     (aluOp),
    .aluIn1    (aluIn1),
    .aluIn2    (aluIn2),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aluOut    (aluOut),
    .flags_out (flags_out),
    .flags_we  (flags_we),
    .flags_in  (flags_in),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h expected=none", aluOut);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_out"},   aluOut,    e.res);
        chk({e.name, "_flags"}, flags_out, e.fl);
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input string name, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic sf, input logic [W-1:0] eres,
                      input logic [3:0] efl, input logic push);
    int n;
    exp_t e;
    aluOp = op; aluIn1 = a; aluIn2 = b; set_flags = sf; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk({name, "_accept_timeout"}, in_ready, 1'b1);
    end
    @(posedge clk);
    if (push) begin
      e.res = eres; e.fl = efl; e.name = name;
      exp_q.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] f);
    flags_in = f;
    flags_we = 1'b1;
    @(posedge clk);
    #1 flags_we = 1'b0;
    chk("flags_we_load", flags_out, f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; aluOp = OP_ADD; aluIn1 = '0; aluIn2 = '0;
    set_flags = 1'b0; out_ready = 1'b1; flags_we = 1'b0; flags_in = 4'b0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_aluOut",    aluOut,    32'h0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_flags",     flags_out, 4'b0000);
    chk("rst_in_ready",  in_ready,  1'b1);

    // ADD overflow, with one-cycle latency check
    send("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 4'b1001, 1'b1);
    @(negedge clk); chk("add_lat_t", out_valid, 1'b0);
    @(negedge clk); chk("add_lat_t1", out_valid, 1'b1);
    @(posedge clk); #1;

    // Carry produced then consumed back-to-back by ADC
    send("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0, 4'b0110, 1'b1);
    send("adc_fwd",   OP_ADC, 32'h2, 32'h3, 1'b1, 32'h6, 4'b0000, 1'b1);

    send("sub_neg", OP_SUB, 32'h5, 32'h3, 1'b1, 32'hFFFF_FFFE, 4'b1000, 1'b1);
    send("sub_pos", OP_SUB, 32'h3, 32'h5, 1'b1, 32'h2,         4'b0010, 1'b1);

    send("ror4",  OP_ROR, 32'h4,  32'h0000_00F1, 1'b1, 32'h1000_000F, 4'b0000, 1'b1);
    send("ror32", OP_ROR, 32'd32, 32'h8000_0001, 1'b1, 32'h8000_0001, 4'b1000, 1'b1);

    send("and_z",  OP_AND, 32'h0000_00F0, 32'h0000_000F, 1'b1, 32'h0,         4'b0100, 1'b1);
    send("eor_n",  OP_EOR, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1, 32'hFFFF_0000, 4'b1000, 1'b1);
    send("orr_nf", OP_ORR, 32'h0000_00F0, 32'h0000_0F00, 1'b0, 32'h0000_0FF0, 4'b1000, 1'b1);
    @(posedge clk); #1;

    // Iterative MUL: C and V must survive
    load_flags(4'b0011);
    send("mul", OP_MUL, 32'h0001_0000, 32'h0001_0003, 1'b1, 32'h0003_0000, 4'b0011, 1'b1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("mul_busy", busy, 1'b1);
      chk("mul_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    chk("mul_busy_end", busy, 1'b0);
    chk("mul_not_yet", out_valid, 1'b0);
    @(negedge clk);
    chk("mul_valid", out_valid, 1'b1);
    @(posedge clk); #1;

    // MUL aborted by reset at cycle 10
    load_flags(4'b1010);
    send("mul_abort", OP_MUL, 32'h5, 32'h7, 1'b1, 32'h23, 4'b0000, 1'b0);
    repeat (9) @(posedge clk);
    #1 chk("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_busy",      busy,      1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_flags",     flags_out, 4'b0000);
    chk("abort_in_ready",  in_ready,  1'b1);
    repeat (40) @(negedge clk);
    chk("abort_no_result", out_valid, 1'b0);
    @(posedge clk); #1;

    // Output hold under back-pressure
    out_ready = 1'b0;
    send("hold_add", OP_ADD, 32'h1, 32'h1, 1'b1, 32'h2, 4'b0000, 1'b1);
    @(negedge clk); chk("hold_lat", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_out",   aluOut,    32'h2);
      chk("hold_ready", in_ready,  1'b0);
      chk("hold_flags", flags_out, 4'b0000);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 chk("hold_drop", out_valid, 1'b0);

    // flags_we beats a commit on the same edge; ADC then sees C=1
    send("we_add", OP_ADD, 32'h1, 32'h1, 1'b1, 32'h2, 4'b1111, 1'b1);
    flags_in = 4'b1111; flags_we = 1'b1;
    @(posedge clk);
    #1 flags_we = 1'b0;
    send("we_adc", OP_ADC, 32'h0, 32'h0, 1'b1, 32'h1, 4'b0000, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational execute-stage ALU.
- Accepts one operation per valid/ready handshake and returns a registered result with NZCV flags.
- Holds the NZCV flags in an internal architectural register, so ADC uses the stored carry instead of a loose input.
- Adds ORR, EOR, ADC and an iterative MUL, plus output back-pressure. Sits between operand fetch and writeback in the core.

Parameters:
- WIDTH, 32, datapath width; power of two, 8..64.
- FLAGS_RST, 4'b0000, reset value of {N,Z,C,V}.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept operation this cycle
- aluOp  in  3  000 ADD, 001 ADC, 010 SUB, 011 AND, 100 ORR, 101 EOR, 110 ROR, 111 MUL
- aluIn1  in  WIDTH  operand 1; SUB subtrahend; ROR amount
- aluIn2  in  WIDTH  operand 2; SUB minuend; ROR data
- set_flags  in  1  commit flags for this operation
- out_valid  out  1  aluOut valid
- out_ready  in  1  consumer takes result
- aluOut  out  WIDTH  result
- flags_out  out  4  {N,Z,C,V} architectural register
- flags_we  in  1  external flag load (MSR-style)
- flags_in  in  4  value for flags_we
- busy  out  1  MUL in progress

Behaviour:
- Reset: state IDLE, out_valid=0, aluOut=0, busy=0, flags_out=FLAGS_RST. Reset mid-MUL aborts the op: no result and no flag commit.
- Accept: accept = in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready). Operands, op and set_flags are captured on accept.
- Single-cycle ops (000-110): accept at edge t; aluOut/out_valid valid after edge t+1. Throughput is one op per cycle while out_ready=1.
- MUL: state goes IDLE->MUL_BUSY with busy=1 for WIDTH cycles (one shift-add bit per cycle).
  - Result is the low WIDTH bits of the product; out_valid rises after edge t+WIDTH+1.
  - MUL_BUSY->IDLE on completion.
- Output hold: while out_valid && !out_ready, aluOut and out_valid are held and no new op is accepted. out_valid drops on the handshake edge unless a new single-cycle result lands in the same edge.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: in1+in2. ADC: in1+in2+C (C from flag register).
  - SUB: in2-in1.
  - ROR: in2 rotated right by in1[$clog2(WIDTH)-1:0]; upper amount bits ignored.
- Flags are computed at result-register time and written to flags_out on the same edge as the result, only if set_flags:
  - N = aluOut[MSB]. Z = (aluOut==0).
  - ADD/ADC: C = carry-out; V = signed overflow (same-sign operands, different-sign result).
  - SUB: C = 1 iff no borrow (in2 >= in1 unsigned); V = signed overflow of in2-in1.
  - AND/ORR/EOR/MUL: C and V unchanged.
  - ROR: C = aluOut[MSB] if amount != 0, otherwise unchanged; V unchanged.
- ADC read timing: ADC reads the C flag value present at its accept edge. A back-to-back flag-setting op retires on that same edge, so its new C is forwarded to the ADC.
- Flag write priority: flags_we writes flags_in on the next edge. If it coincides with a flag commit, flags_we wins.

Decomposition:
- Shared package alu_pkg holds:
  - aluOp encodings as localparams.
  - Flag bit indices: N=3, Z=2, C=1, V=0.
  - State encoding: IDLE, MUL_BUSY.
- One sub-module, alu_mul_iter: start/done shift-add multiplier, WIDTH-cycle latency, low-half product.

Test Plan:
- ADD, in1=0x7FFFFFFF, in2=1, set_flags=1 -> aluOut=0x80000000 one cycle later; flags N=1 Z=0 C=0 V=1.
- ADD 0xFFFFFFFF+1 with flags, then ADC in1=2, in2=3 back-to-back -> first op aluOut=0, Z=1 C=1; then aluOut=6 with C=0.
- SUB in1=5, in2=3, set_flags=1 -> aluOut=0xFFFFFFFE, N=1 C=0 V=0. Then SUB in1=3, in2=5 -> aluOut=2, C=1.
- ROR in1=4, in2=0x000000F1 -> aluOut=0x1000000F, C=0. Then ROR in1=32, in2=0x80000001 -> aluOut unchanged, C unchanged.
- MUL in1=0x00010000, in2=0x00010003 -> busy=1 and in_ready=0 for 32 cycles; aluOut=0x00030000 after 33 cycles. Repeat with reset asserted at cycle 10 -> IDLE next cycle, out_valid=0, flags=FLAGS_RST.
- ADD 1+1 with out_ready=0 for 3 cycles -> aluOut=2 held and in_ready=0 throughout; flags committed exactly once. Same-cycle flags_we=1, flags_in=4'b1111 with a flag-setting op -> flags_out=4'b1111.
